pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//   Owns the fetch PC register and selects the next PC: sequential fetch, taken branch, j/jal, or jr.
//   Forms the branch target as sign-extended offset << 2 plus PC+4, and the jump target from
//   PC+4[31:28] and the 26-bit index << 2. Branches resolve in ID with no delay slot.
//   Sits between the hazard unit, the ID-stage branch compare, and instruction memory / the IF/ID register.
// PARAMETERS
//   RESET_PC  32'h0000_0000  fetch address loaded on reset
//   CNT_W     16             width of the redirect performance counter
// PORTS
//   clk          in   1      single clock, rising edge
//   reset        in   1      asynchronous, active-high
//   stall        in   1      hazard unit: freeze PC and IF/ID
//   br_valid     in   1      conditional branch resolved in ID this cycle
//   br_taken     in   1      branch outcome; qualified by br_valid
//   br_pc4       in   32     PC+4 of the ID-stage control instruction
//   br_imm       in   16     raw 16-bit branch offset (words)
//   jmp_valid    in   1      j/jal in ID
//   jmp_index    in   26     jump index field
//   jr_valid     in   1      jr in ID
//   jr_target    in   32     register-sourced target
//   pc           out  32     fetch address (registered)
//   pc_plus4     out  32     pc + 4 (registered, wraps mod 2^32)
//   flush_ifid   out  1      combinational: clear IF/ID at this edge
//   misaligned   out  1      sticky: jr target had nonzero [1:0]
//   redirect_cnt out  CNT_W  accepted redirects, wraps
// BEHAVIOUR
//   Reset (async): pc=RESET_PC, pc_plus4=RESET_PC+4, misaligned=0, redirect_cnt=0, pend=0, state=BOOT.
//   flush_ifid is 0 in BOOT and whenever no redirect is accepted.
//   Request: req = jr_valid | jmp_valid | (br_valid & br_taken).
//   Priority: jr > jmp > branch when more than one is valid.
//   Targets:
//     branch = br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00}
//     jump   = {br_pc4[31:28], jmp_index, 2'b00}
//     jr     = {jr_target[31:2], 2'b00}
//   All adds are modulo 2^32.
//   States:
//     BOOT: hold pc for 1 cycle (first IMEM read); ignore all inputs; then go to RUN.
//     RUN, stall=0, req=1:  pc<=target; flush_ifid=1; cnt++; stay in RUN.
//     RUN, stall=0, req=0:  pc<=pc_plus4.
//     RUN, stall=1, req=1:  pc held; latch target into pend_tgt; go to PEND; flush_ifid=0.
//     RUN, stall=1, req=0:  pc held.
//     PEND, stall=1:        pc held; new requests ignored (same ID instruction re-asserts).
//     PEND, stall=0:        pc<=pend_tgt; flush_ifid=1; cnt++; go to RUN; inputs this cycle ignored.
//   Latency: redirect accepted in cycle N gives pc=target in cycle N+1; exactly one wrong-path
//     fetch is squashed.
//   misaligned: set at any edge where jr is the selected request and jr_target[1:0]!=0;
//     cleared only by reset.
//   Wrap: pc=32'hFFFF_FFFC increments to 0. redirect_cnt wraps at 2^CNT_W-1 to 0.
//   Reset mid-PEND: pending target is discarded and state returns to BOOT.
// STRUCTURE
//   Include pc_defs.vh holds the state encodings (BOOT/RUN/PEND), the RESET_PC default and
//   the word-offset shift amount (2).
//   Sub-module branch_target_calc: combinational sign-extend, <<2, add; reused by the ID stage.
//   All remaining logic stays in this module: FSM, pend_tgt register, priority mux, counter.
// TESTING
//   1. Reset, no requests, 4 cycles -> pc: 0 (BOOT), 0, 4, 8; flush_ifid=0 throughout.
//   2. br_pc4=0x100, br_imm=0xFFFE, taken, no stall -> next pc=0xF8; flush_ifid=1 for 1 cycle;
//      redirect_cnt=1.
//   3. jmp_index=0x0000040, br_pc4=0x8000_0010 -> next pc=0x8000_0100; a simultaneous
//      taken branch is ignored.
//   4. Taken branch with stall=1 for 3 cycles -> pc frozen, flush_ifid=0; in the stall=0 cycle
//      flush_ifid=1, next pc=target; cnt increments once.
//   5. jr_target=0x0000_2003 -> next pc=0x2000; misaligned=1 and stays set after later
//      aligned jr; reset clears it.
//   6. pc=0xFFFF_FFFC, no request -> next pc=0. Assert reset while in PEND -> pc=RESET_PC
//      immediately and the pending target is never loaded.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer.
//   state_e        : sequencer FSM states (boot hold, running, pending redirect)
//   WordShift      : word-offset to byte-offset shift amount
//   DefaultResetPc : default fetch address after reset
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StPend = 2'd2
  } state_e;

  localparam int unsigned WordShift      = 2;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_branch_target_calc.sv
// Combinational branch target: sign-extend the 16-bit word offset, convert it to a
// byte offset and add it to PC+4 (modulo 2^32). Also usable directly by the ID stage.
//   pc4_i    : PC+4 of the branch instruction
//   imm_i    : raw 16-bit branch offset in words
//   target_o : branch target address
module pc_sequencer_branch_target_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc4_i,
  input  logic [15:0] imm_i,
  output logic [31:0] target_o
);

  logic [31:0] offset;

  always_comb begin
    offset   = {{16{imm_i[15]}}, imm_i} << WordShift;
    target_o = pc4_i + offset;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register and next-PC selection: sequential fetch, taken branch, j/jal or jr.
// A redirect seen while stalled is parked in pend_tgt and applied when the stall lifts.
//   clk, reset             : clock and asynchronous active-high reset
//   stall                  : freeze PC and IF/ID
//   br_valid/br_taken      : conditional branch resolved in ID and its outcome
//   br_pc4, br_imm         : PC+4 of the ID instruction and raw branch word offset
//   jmp_valid, jmp_index   : j/jal in ID and its 26-bit index
//   jr_valid, jr_target    : jr in ID and its register-sourced target
//   pc, pc_plus4           : registered fetch address and its successor
//   flush_ifid             : combinational; squash IF/ID at this edge
//   misaligned             : sticky; a selected jr had a nonzero low address pair
//   redirect_cnt           : count of accepted redirects (wraps)
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [31:0]      br_pc4,
  input  logic [15:0]      br_imm,
  input  logic             jmp_valid,
  input  logic [25:0]      jmp_index,
  input  logic             jr_valid,
  input  logic [31:0]      jr_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             flush_ifid,
  output logic             misaligned,
  output logic [CNT_W-1:0] redirect_cnt
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4_q;
  logic [31:0]      pend_tgt_q, pend_tgt_d;
  logic             misaligned_q, misaligned_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] br_tgt;
  logic [31:0] sel_tgt;
  logic        req;

  pc_sequencer_branch_target_calc u_br_calc (
    .pc4_i    (br_pc4),
    .imm_i    (br_imm),
    .target_o (br_tgt)
  );

  // Priority mux: jr > jmp > branch.
  always_comb begin
    req = jr_valid | jmp_valid | (br_valid & br_taken);
    if (jr_valid) begin
      sel_tgt = {jr_target[31:2], 2'b00};
    end else if (jmp_valid) begin
      sel_tgt = {br_pc4[31:28], jmp_index, 2'b00};
    end else begin
      sel_tgt = br_tgt;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_tgt_d   = pend_tgt_q;
    misaligned_d = misaligned_q;
    cnt_d        = cnt_q;
    flush_ifid   = 1'b0;
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
      end
      StRun: begin
        if (jr_valid && (jr_target[1:0] != 2'b00)) begin
          misaligned_d = 1'b1;
        end
        if (!stall) begin
          if (req) begin
            pc_d       = sel_tgt;
            flush_ifid = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
          end else begin
            pc_d = pc_plus4_q;
          end
        end else if (req) begin
          pend_tgt_d = sel_tgt;
          state_d    = StPend;
        end
      end
      StPend: begin
        // Requests are ignored here: the stalled ID instruction re-asserts the same one.
        if (!stall) begin
          pc_d       = pend_tgt_q;
          flush_ifid = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          state_d    = StRun;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StBoot;
      pc_q         <= RESET_PC;
      pc_plus4_q   <= RESET_PC + 32'd4;
      pend_tgt_q   <= 32'h0;
      misaligned_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_plus4_q   <= pc_d + 32'd4;
      pend_tgt_q   <= pend_tgt_d;
      misaligned_q <= misaligned_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_plus4_q;
  assign misaligned   = misaligned_q;
  assign redirect_cnt = cnt_q;

endmodule
